// File: rtl/regfile_access_ctrl.sv
// Access controller for a synchronous-read BRAM register file: power-up clear,
// one-cycle-latency dual-operand reads with write forwarding, and a write-back port.
module regfile_access_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK1,
  input  logic        RST1,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [4:0]  REQ_RS1,
  input  logic [4:0]  REQ_RS2,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RS1_DATA,
  output logic [31:0] RSP_RS2_DATA,
  input  logic        WR_EN,
  output logic        WR_READY,
  input  logic [4:0]  WR_ADDR,
  input  logic [31:0] WR_DATA,
  output logic [4:0]  A1ADDR,
  output logic [4:0]  A2ADDR,
  input  logic [31:0] A1DATA,
  input  logic [31:0] A2DATA,
  output logic [4:0]  B1ADDR,
  output logic [31:0] B1DATA,
  output logic        B1EN,
  output logic        INIT_DONE
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [4:0]  held_rs1_q, held_rs1_d;
  logic [4:0]  held_rs2_q, held_rs2_d;
  logic        fwd_v_q;
  logic [4:0]  fwd_addr_q;
  logic [31:0] fwd_data_q;
  logic        wr_ok;
  logic        accept;

  // Outputs are also gated by RST1 so nothing is written or accepted while reset is held.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    B1EN      = 1'b0;
    B1ADDR    = '0;
    B1DATA    = '0;
    wr_ok     = 1'b0;
    REQ_READY = 1'b0;
    INIT_DONE = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        B1EN   = !RST1;
        B1ADDR = cnt_q;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_ok     = !RST1;
        INIT_DONE = !RST1;
        REQ_READY = !RST1 && (!rsp_valid_q || RSP_READY);
        B1EN      = WR_EN && wr_ok && (WR_ADDR != 5'd0);
        B1ADDR    = WR_ADDR;
        B1DATA    = WR_DATA;
      end
      default: state_d = RST_STATE;
    endcase
  end

  assign WR_READY = wr_ok;
  assign accept   = REQ_VALID && REQ_READY;

  always_comb begin
    held_rs1_d  = held_rs1_q;
    held_rs2_d  = held_rs2_q;
    rsp_valid_d = rsp_valid_q;
    if (accept) begin
      held_rs1_d  = REQ_RS1;
      held_rs2_d  = REQ_RS2;
      rsp_valid_d = 1'b1;
    end else if (RSP_READY) begin
      rsp_valid_d = 1'b0;
    end
  end

  // The BRAM re-reads the held index every cycle, so a stalled response follows writes.
  assign A1ADDR    = accept ? REQ_RS1 : held_rs1_q;
  assign A2ADDR    = accept ? REQ_RS2 : held_rs2_q;
  assign RSP_VALID = rsp_valid_q;

  always_comb begin
    RSP_RS1_DATA = A1DATA;
    if (held_rs1_q == 5'd0)                          RSP_RS1_DATA = '0;
    else if (fwd_v_q && (fwd_addr_q == held_rs1_q)) RSP_RS1_DATA = fwd_data_q;
  end

  always_comb begin
    RSP_RS2_DATA = A2DATA;
    if (held_rs2_q == 5'd0)                          RSP_RS2_DATA = '0;
    else if (fwd_v_q && (fwd_addr_q == held_rs2_q)) RSP_RS2_DATA = fwd_data_q;
  end

  always_ff @(posedge CLK1 or posedge RST1) begin
    if (RST1) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      held_rs1_q  <= '0;
      held_rs2_q  <= '0;
      fwd_v_q     <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      held_rs1_q  <= held_rs1_d;
      held_rs2_q  <= held_rs2_d;
      fwd_v_q     <= B1EN;
      fwd_addr_q  <= B1ADDR;
      fwd_data_q  <= B1DATA;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a read-old-data BRAM model attached.
module tb_regfile_access_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  rs1, rs2;
  logic [31:0] d1, d2;
  logic        wr_en, wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  a1addr, a2addr, b1addr;
  logic [31:0] a1data, a2data, b1data;
  logic        b1en, init_done;

  // second instance with no clear phase
  logic        n_req_ready, n_rsp_valid, n_wr_ready, n_b1en, n_init_done;
  logic [31:0] n_d1, n_d2, n_b1data;
  logic [4:0]  n_a1addr, n_a2addr, n_b1addr;

  logic [31:0] mem [32];
  int unsigned n_vec;
  int unsigned n_fail;

  regfile_access_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
    .CLK1(clk), .RST1(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_RS1(rs1), .REQ_RS2(rs2),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RS1_DATA(d1), .RSP_RS2_DATA(d2),
    .WR_EN(wr_en), .WR_READY(wr_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .A1ADDR(a1addr), .A2ADDR(a2addr), .A1DATA(a1data), .A2DATA(a2data),
    .B1ADDR(b1addr), .B1DATA(b1data), .B1EN(b1en), .INIT_DONE(init_done)
  );

  regfile_access_ctrl #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .CLK1(clk), .RST1(rst),
    .REQ_VALID(1'b0), .REQ_READY(n_req_ready), .REQ_RS1(5'd0), .REQ_RS2(5'd0),
    .RSP_VALID(n_rsp_valid), .RSP_READY(1'b1), .RSP_RS1_DATA(n_d1), .RSP_RS2_DATA(n_d2),
    .WR_EN(1'b0), .WR_READY(n_wr_ready), .WR_ADDR(5'd0), .WR_DATA(32'd0),
    .A1ADDR(n_a1addr), .A2ADDR(n_a2addr), .A1DATA(32'd0), .A2DATA(32'd0),
    .B1ADDR(n_b1addr), .B1DATA(n_b1data), .B1EN(n_b1en), .INIT_DONE(n_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b1en) mem[b1addr] <= b1data;
    a1data <= mem[a1addr];
    a2data <= mem[a2addr];
  end

  typedef struct {
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  r1, r2;
    logic        rr;
    logic        e_rdy, e_val, e_b1en, chk_d;
    logic [31:0] e_d1, e_d2;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rv, input logic [4:0] r1, input logic [4:0] r2,
                              input logic rr, input logic e_rdy, input logic e_val,
                              input logic e_b1en, input logic chk_d,
                              input logic [31:0] e_d1, input logic [31:0] e_d2);
    vec_t v;
    v.wr_en = we; v.wa = wa; v.wd = wd; v.rv = rv; v.r1 = r1; v.r2 = r2; v.rr = rr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_b1en = e_b1en; v.chk_d = chk_d;
    v.e_d1 = e_d1; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; rs1 = '0; rs2 = '0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  // Expects RST1 to have just been released shortly after a posedge.
  task automatic clear_run();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("clr_b1en[%0d]", i), {31'd0, b1en}, 32'd1);
      chk($sformatf("clr_b1addr[%0d]", i), {27'd0, b1addr}, i);
      chk($sformatf("clr_b1data[%0d]", i), b1data, 32'd0);
      chk($sformatf("clr_busy[%0d]", i), {29'd0, init_done, req_ready, wr_ready}, 32'd0);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    chk("clr_done_init", {31'd0, init_done}, 32'd1);
    chk("clr_done_req_ready", {31'd0, req_ready}, 32'd1);
    chk("clr_done_wr_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  function automatic logic [31:0] seqval(input int i);
    return 32'h1000_0000 + i;
  endfunction

  initial begin
    n_vec = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 | i;
    a1data = '0; a2data = '0;

    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    vt[1]  = mk(0, 0, 0,            1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0,            0, 0, 0, 1, 1, 1, 0, 1, 32'hDEADBEEF, 0);
    vt[3]  = mk(1, 7, 32'h12345678, 1, 7, 7, 1, 1, 0, 1, 0, 0, 0);
    vt[4]  = mk(0, 0, 0,            0, 0, 0, 1, 1, 1, 0, 1, 32'h12345678, 32'h12345678);
    vt[5]  = mk(0, 0, 0,            1, 3, 4, 0, 1, 0, 0, 0, 0, 0);
    vt[6]  = mk(0, 0, 0,            1, 9, 9, 0, 0, 1, 0, 1, 0, 0);
    vt[7]  = mk(1, 3, 32'hA5A5A5A5, 1, 9, 9, 0, 0, 1, 1, 1, 0, 0);
    vt[8]  = mk(0, 0, 0,            1, 9, 9, 0, 0, 1, 0, 1, 32'hA5A5A5A5, 0);
    vt[9]  = mk(0, 0, 0,            0, 0, 0, 1, 1, 1, 0, 1, 32'hA5A5A5A5, 0);
    vt[10] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vt[11] = mk(0, 0, 0,            1, 5, 3, 1, 1, 1, 0, 1, 0, 0);
    vt[12] = mk(0, 0, 0,            0, 0, 0, 1, 1, 1, 0, 1, 32'hDEADBEEF, 32'hA5A5A5A5);
    vt[13] = mk(0, 0, 0,            0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_b1en", {31'd0, b1en}, 32'd0);
    chk("nc_rst_init_done", {31'd0, n_init_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("nc_init_done", {31'd0, n_init_done}, 32'd1);
    chk("nc_req_ready", {31'd0, n_req_ready}, 32'd1);
    @(posedge clk);
    // rewind: the clear sequence is checked from the first negedge after release
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    clear_run();

    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      wr_en = vt[k].wr_en; wr_addr = vt[k].wa; wr_data = vt[k].wd;
      req_valid = vt[k].rv; rs1 = vt[k].r1; rs2 = vt[k].r2; rsp_ready = vt[k].rr;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", k), {31'd0, req_ready}, {31'd0, vt[k].e_rdy});
      chk($sformatf("v%0d_rsp_valid", k), {31'd0, rsp_valid}, {31'd0, vt[k].e_val});
      chk($sformatf("v%0d_b1en", k), {31'd0, b1en}, {31'd0, vt[k].e_b1en});
      if (vt[k].chk_d) begin
        chk($sformatf("v%0d_rs1_data", k), d1, vt[k].e_d1);
        chk($sformatf("v%0d_rs2_data", k), d2, vt[k].e_d2);
      end
    end

    // fill x1..x8, then stream reads back-to-back
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      idle_inputs();
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = seqval(i);
    end
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      idle_inputs();
      req_valid = 1'b1;
      rs1 = (i <= 8) ? 5'(i) : 5'd1;
      rs2 = (i <= 8) ? 5'(9 - i) : 5'd2;
      @(negedge clk);
      chk($sformatf("b2b_req_ready[%0d]", i), {31'd0, req_ready}, 32'd1);
      if (i > 1) begin
        chk($sformatf("b2b_valid[%0d]", i), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("b2b_rs1[%0d]", i), d1, seqval(i - 1));
        chk($sformatf("b2b_rs2[%0d]", i), d2, seqval(10 - i));
      end
    end

    // reset while a response is pending
    @(posedge clk);
    #1;
    rst = 1'b1;
    rs1 = 5'd3; rs2 = 5'd4;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_init_done", {31'd0, init_done}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    clear_run();

    @(posedge clk);
    #1;
    req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd1;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("postclr_valid", {31'd0, rsp_valid}, 32'd1);
    chk("postclr_rs1", d1, 32'd0);
    chk("postclr_rs2", d2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
